mod_n_seq_checker: RTL and testbench

- Receive-side checker for the team's mod-N counters; samples a counter output bus each clock and verifies it follows the sequence 0,1,…,MODULUS-1,0.
- Acquires lock after a run of correct successors, then flags sequence errors, counts them and marks wrap events.
- Sits beside any mod-N counter instance as an in-design monitor or bench scoreboard.

---
 rtl/seq_chk_pkg.sv | 5 +
 rtl/mod_n_succ.sv | 12 +
 rtl/mod_n_seq_checker.sv | 97 +++++++++
 tb/tb_mod_n_seq_checker.sv | 119 +++++++++++
 4 files changed

// File: rtl/seq_chk_pkg.sv
// seq_chk_pkg: shared state encoding and saturation constant for the mod-N sequence checker
package seq_chk_pkg;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ACQ = 2'd1, ST_LOCKED = 2'd2} state_t;
  localparam logic [31:0] ERR_SAT = '1;
endpackage

// File: rtl/mod_n_succ.sv
// mod_n_succ: combinational mod-N successor and range check
module mod_n_succ #(
  parameter int MODULUS = 6,
  parameter int WIDTH   = 3
) (
  input  logic [WIDTH-1:0] i_x,
  output logic [WIDTH-1:0] o_succ,
  output logic             o_in_range
);
  assign o_in_range = int'(i_x) < MODULUS;
  assign o_succ     = (i_x == WIDTH'(MODULUS - 1)) ? '0 : i_x + 1'b1;
endmodule

// File: rtl/mod_n_seq_checker.sv
// mod_n_seq_checker: locks onto a 0..MODULUS-1 counter stream, flags errors and wraps
// Optional SEQ_CHK_STICKY_ERR_EN adds err_sticky and keeps lock through mismatches once set.
module mod_n_seq_checker
  import seq_chk_pkg::*;
#(
  parameter int MODULUS  = 6,
  parameter int WIDTH    = 3,
  parameter int LOCK_CNT = 3,
  parameter int ERRW     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] q_in,
  input  logic             q_valid,
  output logic             locked,
  output logic             err_pulse,
  output logic             wrap_pulse,
  output logic [ERRW-1:0]  err_count,
`ifdef SEQ_CHK_STICKY_ERR_EN
  output logic             err_sticky,
`endif
  output logic [WIDTH-1:0] expected
);
  localparam int RW = $clog2(LOCK_CNT + 1);
  localparam logic [RW-1:0] LOCK_V = RW'(LOCK_CNT);
  state_t           r_state, n_state;
  logic [WIDTH-1:0] r_expected, n_exp, w_succ;
  logic [RW-1:0]    r_run, n_run;
  logic [ERRW-1:0]  r_err_count;
  logic             r_err_pulse, r_wrap_pulse, n_err, n_wrap;
  logic             w_in_range, w_match, w_keep;
  mod_n_succ #(.MODULUS(MODULUS), .WIDTH(WIDTH)) u_succ (
    .i_x(q_in),
    .o_succ(w_succ),
    .o_in_range(w_in_range)
  );
  assign w_match = w_in_range && (q_in == r_expected);
`ifdef SEQ_CHK_STICKY_ERR_EN
  logic r_sticky;
  always_ff @(posedge clk)
    r_sticky <= reset ? 1'b0 : (r_sticky | n_err);
  assign err_sticky = r_sticky;
  assign w_keep     = r_sticky;
`else
  assign w_keep = 1'b0;
`endif
  always_comb begin
    n_state = r_state;
    n_exp   = r_expected;
    n_run   = r_run;
    n_err   = 1'b0;
    n_wrap  = 1'b0;
    if (q_valid)
      case (r_state)
        ST_IDLE: begin
          n_state = w_in_range ? ST_ACQ : ST_IDLE;
          n_exp   = w_in_range ? w_succ : r_expected;
          n_run   = '0;
        end
        ST_ACQ: begin
          n_run   = w_match ? r_run + 1'b1 : '0;
          n_exp   = w_in_range ? w_succ : r_expected;
          n_state = !w_in_range ? ST_IDLE : (w_match && (r_run + 1'b1) == LOCK_V) ? ST_LOCKED : ST_ACQ;
        end
        ST_LOCKED: begin
          n_err   = !w_match;
          n_wrap  = w_match && (q_in == '0);
          n_exp   = w_in_range ? w_succ : r_expected;
          n_run   = w_match ? r_run : '0;
          n_state = (w_match || w_keep) ? ST_LOCKED : w_in_range ? ST_ACQ : ST_IDLE;
        end
        default: n_state = ST_IDLE;
      endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_expected   <= '0;
      r_run        <= '0;
      r_err_pulse  <= 1'b0;
      r_wrap_pulse <= 1'b0;
      r_err_count  <= '0;
    end else begin
      r_state      <= n_state;
      r_expected   <= n_exp;
      r_run        <= n_run;
      r_err_pulse  <= n_err;
      r_wrap_pulse <= n_wrap;
      r_err_count  <= (n_err && r_err_count != ERR_SAT[ERRW-1:0]) ? r_err_count + 1'b1 : r_err_count;
    end
  end
  assign locked     = r_state == ST_LOCKED;
  assign err_pulse  = r_err_pulse;
  assign wrap_pulse = r_wrap_pulse;
  assign err_count  = r_err_count;
  assign expected   = r_expected;
endmodule

// File: tb/tb_mod_n_seq_checker.sv
// tb_mod_n_seq_checker: directed vector table plus saturation and reset sequences
module tb_mod_n_seq_checker;
  logic       clk = 1'b0;
  logic       reset, q_valid;
  logic [2:0] q_in, expected;
  logic       locked, err_pulse, wrap_pulse;
  logic [7:0] err_count;
`ifdef SEQ_CHK_STICKY_ERR_EN
  logic       err_sticky;
`endif
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  mod_n_seq_checker #(.MODULUS(6), .WIDTH(3), .LOCK_CNT(3), .ERRW(8)) dut (
    .clk(clk), .reset(reset), .q_in(q_in), .q_valid(q_valid),
    .locked(locked), .err_pulse(err_pulse), .wrap_pulse(wrap_pulse),
    .err_count(err_count),
`ifdef SEQ_CHK_STICKY_ERR_EN
    .err_sticky(err_sticky),
`endif
    .expected(expected)
  );
  typedef struct {
    logic v; logic [2:0] q; logic l; logic e; logic w; logic [7:0] c; logic [2:0] x;
  } vec_t;
  vec_t vecs[$];
  task automatic add(input logic v, input logic [2:0] q, input logic l, input logic e,
                     input logic w, input logic [7:0] c, input logic [2:0] x);
    vecs.push_back('{v, q, l, e, w, c, x});
  endtask
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask
  task automatic chk_all(input string tag, input logic l, input logic e, input logic w,
                         input logic [7:0] c, input logic [2:0] x);
    chk({tag, " locked"}, 32'(locked), 32'(l));
    chk({tag, " err_pulse"}, 32'(err_pulse), 32'(e));
    chk({tag, " wrap_pulse"}, 32'(wrap_pulse), 32'(w));
    chk({tag, " err_count"}, 32'(err_count), 32'(c));
    chk({tag, " expected"}, 32'(expected), 32'(x));
  endtask
  task automatic step(input logic v, input logic [2:0] q);
    q_valid = v;
    q_in    = q;
    @(posedge clk);
    #1;
  endtask
  task automatic lock_run();
    step(1'b1, 3'd0); step(1'b1, 3'd1); step(1'b1, 3'd2); step(1'b1, 3'd3);
  endtask
  initial begin
    int cnt;
    reset = 1'b1; q_valid = 1'b0; q_in = 3'd0;
    // row: valid, q, locked, err, wrap, count, expected after the capturing edge
    add(1'b1,3'd0,1'b0,1'b0,1'b0,8'd0,3'd1); add(1'b1,3'd1,1'b0,1'b0,1'b0,8'd0,3'd2);
    add(1'b1,3'd2,1'b0,1'b0,1'b0,8'd0,3'd3); add(1'b1,3'd3,1'b1,1'b0,1'b0,8'd0,3'd4);
    add(1'b1,3'd4,1'b1,1'b0,1'b0,8'd0,3'd5); add(1'b1,3'd5,1'b1,1'b0,1'b0,8'd0,3'd0);
    add(1'b1,3'd0,1'b1,1'b0,1'b1,8'd0,3'd1); add(1'b1,3'd1,1'b1,1'b0,1'b0,8'd0,3'd2);
    add(1'b1,3'd2,1'b1,1'b0,1'b0,8'd0,3'd3); add(1'b1,3'd3,1'b1,1'b0,1'b0,8'd0,3'd4);
    add(1'b1,3'd4,1'b1,1'b0,1'b0,8'd0,3'd5); add(1'b1,3'd5,1'b1,1'b0,1'b0,8'd0,3'd0);
    add(1'b1,3'd2,1'b0,1'b1,1'b0,8'd1,3'd3); add(1'b1,3'd3,1'b0,1'b0,1'b0,8'd1,3'd4);
    add(1'b1,3'd4,1'b0,1'b0,1'b0,8'd1,3'd5); add(1'b1,3'd5,1'b1,1'b0,1'b0,8'd1,3'd0);
    add(1'b1,3'd7,1'b0,1'b1,1'b0,8'd2,3'd0); add(1'b1,3'd7,1'b0,1'b0,1'b0,8'd2,3'd0);
    add(1'b1,3'd0,1'b0,1'b0,1'b0,8'd2,3'd1); add(1'b1,3'd6,1'b0,1'b0,1'b0,8'd2,3'd1);
    add(1'b1,3'd0,1'b0,1'b0,1'b0,8'd2,3'd1); add(1'b1,3'd1,1'b0,1'b0,1'b0,8'd2,3'd2);
    add(1'b1,3'd2,1'b0,1'b0,1'b0,8'd2,3'd3); add(1'b1,3'd3,1'b1,1'b0,1'b0,8'd2,3'd4);
    add(1'b0,3'd7,1'b1,1'b0,1'b0,8'd2,3'd4); add(1'b0,3'd2,1'b1,1'b0,1'b0,8'd2,3'd4);
    add(1'b0,3'd5,1'b1,1'b0,1'b0,8'd2,3'd4); add(1'b0,3'd0,1'b1,1'b0,1'b0,8'd2,3'd4);
    add(1'b0,3'd4,1'b1,1'b0,1'b0,8'd2,3'd4); add(1'b1,3'd4,1'b1,1'b0,1'b0,8'd2,3'd5);
    add(1'b1,3'd5,1'b1,1'b0,1'b0,8'd2,3'd0); add(1'b1,3'd0,1'b1,1'b0,1'b1,8'd2,3'd1);
    add(1'b1,3'd0,1'b0,1'b1,1'b0,8'd3,3'd1); add(1'b1,3'd1,1'b0,1'b0,1'b0,8'd3,3'd2);
    add(1'b1,3'd2,1'b0,1'b0,1'b0,8'd3,3'd3); add(1'b1,3'd3,1'b1,1'b0,1'b0,8'd3,3'd4);
    @(posedge clk); @(posedge clk); #1;
    chk_all("reset", 1'b0, 1'b0, 1'b0, 8'd0, 3'd0);
`ifdef SEQ_CHK_STICKY_ERR_EN
    chk("reset err_sticky", 32'(err_sticky), 32'd0);
`endif
    reset = 1'b0;
    foreach (vecs[i]) begin
      step(vecs[i].v, vecs[i].q);
      chk_all($sformatf("vec%0d", i), vecs[i].l, vecs[i].e, vecs[i].w, vecs[i].c, vecs[i].x);
    end
    cnt = 3;
    for (int k = 0; k < 260; k++) begin
      step(1'b1, 3'd0);
      cnt = (cnt < 255) ? cnt + 1 : 255;
      chk($sformatf("sat%0d err_pulse", k), 32'(err_pulse), 32'd1);
      chk($sformatf("sat%0d err_count", k), 32'(err_count), 32'(cnt));
      step(1'b1, 3'd1); step(1'b1, 3'd2); step(1'b1, 3'd3);
    end
    chk_all("saturated", 1'b1, 1'b0, 1'b0, 8'd255, 3'd4);
    reset = 1'b1;
    step(1'b1, 3'd4);
    chk_all("reset_sat", 1'b0, 1'b0, 1'b0, 8'd0, 3'd0);
    reset = 1'b0;
    lock_run();
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 3'd0); step(1'b1, 3'd1); step(1'b1, 3'd2); step(1'b1, 3'd3);
    end
    chk_all("pre_reset", 1'b1, 1'b0, 1'b0, 8'd4, 3'd4);
`ifdef SEQ_CHK_STICKY_ERR_EN
    chk("pre_reset err_sticky", 32'(err_sticky), 32'd1);
`endif
    reset = 1'b1;
    step(1'b0, 3'd4);
    chk_all("reset_locked", 1'b0, 1'b0, 1'b0, 8'd0, 3'd0);
`ifdef SEQ_CHK_STICKY_ERR_EN
    chk("reset_locked err_sticky", 32'(err_sticky), 32'd0);
`endif
    reset = 1'b0;
    step(1'b0, 3'd0);
    chk_all("post_reset_idle", 1'b0, 1'b0, 1'b0, 8'd0, 3'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
